// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the fifo-to-UART drain stage.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags
// the last cycle of every bit period.
module fifo_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_tick = run && (r_cnt == LAST);

  // Counter is parked at zero between frames so every frame starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || bit_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the fifo and serialises them as UART frames:
// start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// tx and byte_done are registered, so the line lags the state by one clock.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_pop_err,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic              err_sticky,
  input  logic              err_clr
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_parity;
  logic [2:0]        r_bit_idx;
  logic              r_stop_idx;
  logic              r_tx;
  logic              r_pop;
  logic              r_done;
  logic              r_err;
  logic              w_tick;
  logic              w_run;
  logic              w_tx_nxt;
  logic              w_pop_nxt;
  logic              w_last_stop;
  logic              w_done_nxt;

  assign w_run       = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_last_stop = (STOP_BITS < 2) || r_stop_idx;
  assign w_done_nxt  = (r_state == S_STOP) && w_tick && w_last_stop;

  assign tx         = r_tx;
  assign fifo_pop   = r_pop;
  assign byte_done  = r_done;
  assign err_sticky = r_err;
  assign busy       = (r_state != S_IDLE);

  fifo_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_run),
    .bit_tick(w_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, next line level and pop request.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    w_pop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          w_state_nxt = S_POP;
          w_pop_nxt   = 1'b1;
        end
      end
      S_POP:  w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_START;
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt = r_shreg[0];
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_tx_nxt = r_parity;
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick && w_last_stop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_pop  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_pop  <= w_pop_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Shift register, parity and bit/stop indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_shreg  <= fifo_data_out;
        r_parity <= even_parity(fifo_data_out);
      end else if ((r_state == S_DATA) && w_tick) begin
        r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
      end
      if ((r_state == S_DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == S_STOP) && w_tick) begin
        r_stop_idx <= w_last_stop ? 1'b0 : 1'b1;
      end
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (fifo_pop_err) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule
